// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind a valid/ready request
// channel and a valid/ready response channel, with a fixed number of wait
// states between request accept and the RAM access. Misaligned and
// out-of-range addresses are answered with an error response.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_CNT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [3:0]             wait_cnt;
  logic [3:0]             wait_cnt_nxt;
  logic                   access;
  logic                   accept;
  logic                   lat_we;
  logic [31:0]            lat_addr;
  logic [31:0]            lat_wdata;
  logic [3:0]             lat_be;
  logic                   req_bad;
  logic                   do_write;
  logic [ADDR_WIDTH-1:0]  word_idx;
  logic [31:0]            mem [DEPTH];

  // An address is rejected when it is not word aligned or lies above the RAM.
  function automatic logic addr_bad(input logic [31:0] a);
    logic [31:0] hi;
    hi = a >> (ADDR_WIDTH + 2);
    return (a[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

  assign accept   = req_valid && req_ready;
  assign word_idx = lat_addr[ADDR_WIDTH+1:2];
  assign req_bad  = addr_bad(lat_addr);
  assign do_write = access && lat_we && !req_bad;

  // Next-state logic: accept in IDLE, count down wait states, access, respond.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    access       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = WAIT_CNT_INIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt != 4'd0) begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end else begin
          access    = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RESP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      req_ready <= (state_nxt == ST_IDLE);
      rsp_valid <= (state_nxt == ST_RESP);
    end
  end

  // Capture the request fields on accept so the inputs may change afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  // Response data/error are loaded at the access edge and then held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_err   <= req_bad;
      rsp_rdata <= (req_bad || lat_we) ? 32'd0 : mem[word_idx];
    end
  end

  // RAM byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) begin
          mem[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (1, 0 and 3 wait
// states) driven with directed and random load/store traffic, compared
// against a simple array model of the memory.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int checks = 0;
  int errors = 0;
  int ws_tab [3] = '{1, 0, 3};
  logic [31:0] model [3][1024];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: 4 KiB byte space of 1024 words; anything else is an error.
  task automatic model_access(input int d, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              output logic [31:0] rdata, output logic err);
    int idx;
    if ((addr % 4 != 0) || (addr / 4096 != 0)) begin
      rdata = 32'd0;
      err   = 1'b1;
    end else begin
      idx = int'(addr / 4);
      err = 1'b0;
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model[d][idx][8*i +: 8] = wdata[8*i +: 8];
        rdata = 32'd0;
      end else begin
        rdata = model[d][idx];
      end
    end
  endtask

  // One full transaction on instance d with 'stall' cycles of response back-pressure.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int stall,
                     output logic [31:0] rdata, output logic err);
    int n;
    logic [31:0] held;
    logic [31:0] exp_d;
    logic        exp_e;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    rsp_ready[d] = (stall == 0);
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_addr[d]  = 32'hFFFF_FFFF;
    req_wdata[d] = 32'h0BAD_0BAD;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rsp_valid[d] && n < 40);
    check("latency", 32'(n), 32'(ws_tab[d] + 1));
    model_access(d, we, addr, wdata, be, exp_d, exp_e);
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    check("rdata", rsp_rdata[d], exp_d);
    check("err", 32'(rsp_err[d]), 32'(exp_e));
    held = rsp_rdata[d];
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(rsp_valid[d]), 32'd1);
      check("bp_rdata", rsp_rdata[d], held);
      check("bp_req_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    check("end_valid", 32'(rsp_valid[d]), 32'd0);
    check("end_req_ready", 32'(req_ready[d]), 32'd1);
    check("end_rdata_hold", rsp_rdata[d], held);
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    int          d;

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
      req_be[i]    = 4'd0;
      rsp_ready[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      check("rst_req_ready", 32'(req_ready[i]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rdata", rsp_rdata[i], 32'd0);
      check("rst_err", 32'(rsp_err[i]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Store then load.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, rd, er);
    txn(0, 1'b0, 32'h10, 32'd0, 4'b0000, 0, rd, er);
    check("st_ld_value", rd, 32'hDEADBEEF);

    // Byte lanes.
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 0, rd, er);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er);
    txn(0, 1'b0, 32'h20, 32'd0, 4'b0000, 0, rd, er);
    check("lane_merge", rd, 32'h11BB33DD);
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, rd, er);
    txn(0, 1'b0, 32'h20, 32'd0, 4'b1010, 0, rd, er);
    check("be_zero_noop", rd, 32'h11BB33DD);

    // Errors.
    txn(0, 1'b0, 32'h12, 32'd0, 4'b1111, 0, rd, er);
    check("misaligned_err", 32'(er), 32'd1);
    txn(0, 1'b1, 32'h0, 32'h5A5A1234, 4'b1111, 0, rd, er);
    txn(0, 1'b1, 32'h00001000, 32'hCAFEF00D, 4'b1111, 0, rd, er);
    check("oor_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'h0, 32'd0, 4'b0000, 0, rd, er);
    check("oor_no_write", rd, 32'h5A5A1234);

    // Back-pressure for 5 cycles.
    txn(0, 1'b0, 32'h10, 32'd0, 4'b0000, 5, rd, er);

    // Zero and three wait states.
    txn(1, 1'b1, 32'h44, 32'h01020304, 4'b1111, 0, rd, er);
    txn(1, 1'b0, 32'h44, 32'd0, 4'b0000, 2, rd, er);
    txn(2, 1'b1, 32'h44, 32'h0A0B0C0D, 4'b1111, 0, rd, er);
    txn(2, 1'b0, 32'h44, 32'd0, 4'b0000, 1, rd, er);

    // Reset between accept and the access edge drops the store.
    txn(2, 1'b1, 32'h40, 32'h0, 4'b1111, 0, rd, er);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'h40;
    req_wdata[2] = 32'h12345678;
    req_be[2]    = 4'b1111;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check("mid_rst_valid", 32'(rsp_valid[2]), 32'd0);
    check("mid_rst_ready", 32'(req_ready[2]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("no_rsp_after_rst", 32'(rsp_valid[2]), 32'd0);
    end
    txn(2, 1'b0, 32'h40, 32'd0, 4'b0000, 0, rd, er);
    check("rst_store_dropped", rd, 32'h0);

    // Random traffic over a small pool of initialised words.
    for (int dd = 0; dd < 3; dd++)
      for (int k = 0; k < 8; k++)
        txn(dd, 1'b1, 32'h100 + 32'(4 * k), $urandom, 4'b1111, 0, rd, er);
    for (int t = 0; t < 75; t++) begin
      d = t % 3;
      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       a = a + 32'($urandom_range(1, 3));
        1:       a = a | (32'd1 << $urandom_range(12, 31));
        default: a = a;
      endcase
      txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 3), rd, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
